// File: rtl/msx_wait_pkg.sv
// msx_wait_pkg: shared types and helpers for the MSX Z80 wait-state generator.
package msx_wait_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, M1 = 2'd1, MEM = 2'd2, IO = 2'd3} cycle_t;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  typedef enum logic [2:0] {K_NONE, K_M1, K_INTA, K_IO, K_MEM} kind_t;
  localparam int SUM_W = 16;
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b, input int w);
    logic [SUM_W:0] s, m;
    s = {1'b0, a} + {1'b0, b};
    m = (SUM_W+1)'((1 << w) - 1);
    return s > m ? m[SUM_W-1:0] : s[SUM_W-1:0];
  endfunction
  // Refresh is excluded from MEM so it can never start a wait.
  function automatic kind_t classify(input logic m1_n, input logic mreq_n, input logic iorq_n, input logic rfrsh_n);
    return (!m1_n && !mreq_n) ? K_M1 :
           (!m1_n && !iorq_n) ? K_INTA :
           (m1_n && !iorq_n) ? K_IO :
           (m1_n && !mreq_n && rfrsh_n) ? K_MEM : K_NONE;
  endfunction
  function automatic cycle_t cycle_of(input kind_t k);
    return k == K_M1 ? M1 : k == K_MEM ? MEM : (k == K_IO || k == K_INTA) ? IO : NONE;
  endfunction
endpackage

// File: rtl/msx_wait_gen.sv
// msx_wait_gen: per-cycle-class Z80 wait-state generator with turbo bypass and external wait merge.
module msx_wait_gen
  import msx_wait_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int M1_WAITS = 1,
  parameter int MEM_WAITS = 0,
  parameter int IO_WAITS = 0,
  parameter int INTA_WAITS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             m1_n,
  input  logic             mreq_n,
  input  logic             iorq_n,
  input  logic             rfrsh_n,
  input  logic             exwait_n,
  input  logic             turbo,
  input  logic [CNT_W-1:0] io_extra,
  output logic             wait_n,
  output logic [1:0]       cycle_type,
  output logic             busy
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic iwait_q, iwait_d;
  cycle_t ctype_q, ctype_d;
  kind_t kind;
  logic [CNT_W-1:0] io_load, load;
  logic bus_idle, last;
  assign kind = classify(m1_n, mreq_n, iorq_n, rfrsh_n);
  assign bus_idle = mreq_n & iorq_n;
  assign last = cnt_q == CNT_W'(1);
  assign io_load = CNT_W'(sat_add(SUM_W'(IO_WAITS), SUM_W'(io_extra), CNT_W));
  assign load = turbo ? '0 :
                kind == K_M1 ? CNT_W'(M1_WAITS) :
                kind == K_INTA ? CNT_W'(INTA_WAITS) :
                kind == K_IO ? io_load :
                kind == K_MEM ? CNT_W'(MEM_WAITS) : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    iwait_d = iwait_q;
    ctype_d = ctype_q;
    if (clk_en)
      case (state_q)
        IDLE: if (kind != K_NONE) begin
          ctype_d = cycle_of(kind);
          state_d = load != '0 ? WAIT : HOLD;
          cnt_d = load;
          iwait_d = load == '0;
        end
        WAIT: begin
          state_d = bus_idle ? IDLE : last ? HOLD : WAIT;
          cnt_d = (bus_idle || last) ? '0 : cnt_q - 1'b1;
          iwait_d = bus_idle || last;
        end
        HOLD: state_d = bus_idle ? IDLE : HOLD;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      iwait_q <= 1'b1;
      ctype_q <= NONE;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      iwait_q <= iwait_d;
      ctype_q <= ctype_d;
    end
  assign wait_n = iwait_q & exwait_n;
  assign cycle_type = ctype_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_msx_wait_gen.sv
// tb_msx_wait_gen: directed and random bus cycles checked against a wait-budget reference model.
module tb_msx_wait_gen;
  localparam int CW = 3, M1W = 1, MEMW = 1, IOW = 2, INTAW = 2;
  logic clk, reset, clk_en, m1_n, mreq_n, iorq_n, rfrsh_n, exwait_n, turbo;
  logic [CW-1:0] io_extra;
  logic wait_n, busy;
  logic [1:0] cycle_type;
  int vectors, miscompares;
  int left, ctype_m;
  bit armed, rnd_ex;
  msx_wait_gen #(.CNT_W(CW), .M1_WAITS(M1W), .MEM_WAITS(MEMW), .IO_WAITS(IOW), .INTA_WAITS(INTAW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rfrsh_n(rfrsh_n), .exwait_n(exwait_n), .turbo(turbo), .io_extra(io_extra),
    .wait_n(wait_n), .cycle_type(cycle_type), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Each bus cycle owes a number of wait periods; once paid, the cycle must end before another starts.
  task automatic model_tick();
    bit m1, inta, io, mem, idle;
    int l;
    m1 = !m1_n && !mreq_n;
    inta = !m1_n && !iorq_n;
    io = m1_n && !iorq_n;
    mem = m1_n && !mreq_n && rfrsh_n;
    idle = mreq_n && iorq_n;
    if (armed) begin
      if (m1 || inta || io || mem) begin
        l = m1 ? M1W : inta ? INTAW : io ? ((IOW + int'(io_extra) > 7) ? 7 : IOW + int'(io_extra)) : MEMW;
        left = turbo ? 0 : l;
        ctype_m = m1 ? 1 : (inta || io) ? 3 : 2;
        armed = 0;
      end
    end else if (left > 0) begin
      if (idle) begin
        left = 0;
        armed = 1;
      end else left--;
    end else if (idle) armed = 1;
  endtask
  task automatic check();
    logic ew, eb;
    logic [1:0] ec;
    ew = (left == 0) && exwait_n;
    eb = !armed;
    ec = 2'(ctype_m);
    vectors++;
    assert (wait_n === ew) else begin miscompares++; $error("FAIL wait_n got %b exp %b at %0t", wait_n, ew, $time); end
    vectors++;
    assert (busy === eb) else begin miscompares++; $error("FAIL busy got %b exp %b at %0t", busy, eb, $time); end
    vectors++;
    assert (cycle_type === ec) else begin miscompares++; $error("FAIL cycle_type got %0d exp %0d at %0t", cycle_type, ec, $time); end
  endtask
  task automatic cyc(input bit en);
    clk_en = en;
    if (rnd_ex) exwait_n = ($urandom_range(0, 3) != 0);
    if (reset) begin
      left = 0;
      armed = 1;
      ctype_m = 0;
    end else if (en) model_tick();
    @(posedge clk);
    #1;
    check();
  endtask
  task automatic tick();
    repeat ($urandom_range(0, 2)) cyc(0);
    cyc(1);
  endtask
  task automatic strobes(input int k);
    m1_n = !(k == 0 || k == 3);
    mreq_n = !(k == 0 || k == 1 || k == 4);
    iorq_n = !(k == 2 || k == 3);
    rfrsh_n = k != 4;
  endtask
  task automatic bus(input int k, input int n);
    strobes(k);
    repeat (n) tick();
    strobes(5);
    repeat ($urandom_range(1, 2)) tick();
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    rnd_ex = 0;
    reset = 1;
    clk_en = 0;
    exwait_n = 1;
    turbo = 0;
    io_extra = '0;
    strobes(5);
    left = 0;
    armed = 1;
    ctype_m = 0;
    cyc(1);
    cyc(0);
    reset = 0;
    tick();
    bus(0, 4);
    bus(1, 4);
    io_extra = 3;
    bus(2, 8);
    io_extra = 7;
    bus(2, 10);
    turbo = 1;
    bus(0, 4);
    bus(2, 8);
    turbo = 0;
    io_extra = 3;
    strobes(2);
    tick();
    tick();
    turbo = 1;
    repeat (6) tick();
    strobes(5);
    tick();
    turbo = 0;
    strobes(0);
    exwait_n = 0;
    repeat (4) tick();
    exwait_n = 1;
    strobes(5);
    repeat (2) tick();
    bus(4, 4);
    bus(3, 5);
    io_extra = 1;
    strobes(2);
    tick();
    tick();
    reset = 1;
    cyc(0);
    reset = 0;
    strobes(5);
    tick();
    bus(0, 4);
    io_extra = 5;
    bus(2, 2);
    rnd_ex = 1;
    for (int i = 0; i < 80; i++) begin
      turbo = ($urandom_range(0, 4) == 0);
      io_extra = CW'($urandom_range(0, 7));
      strobes($urandom_range(0, 4));
      repeat ($urandom_range(1, 8)) begin
        if ($urandom_range(0, 9) == 0) turbo = ~turbo;
        tick();
      end
      strobes(5);
      repeat ($urandom_range(1, 2)) tick();
      if ($urandom_range(0, 19) == 0) begin
        reset = 1;
        cyc($urandom_range(0, 1) == 1);
        reset = 0;
      end
    end
    rnd_ex = 0;
    exwait_n = 1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
